// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   kp_state_t  : debounce FSM states
//   scan_res_t  : per-scan classification (NONE / SINGLE / MULTI)
//   KEYMAP      : (row, col) -> hex key code, indexed {row, col}
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } kp_state_t;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } scan_res_t;

    // Entry {r,c}. Rows: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = E 0 F D.
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
        return KEYMAP[{r, c}];
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and consumer-side signals of the scanner.
//   row       : keypad rows, active-low, asynchronous
//   col       : column drive, active-low one-hot
//   key       : last accepted hex key
//   key_valid : one-cycle pulse on a newly accepted key
//   key_held  : high from acceptance until debounced release
// master = scanner, slave = keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (input row, output col, output key, output key_valid, output key_held);
    modport slave  (output row, input col, input key, input key_valid, input key_held);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input bus
//   q        : synchronized output (reset value RST_VAL)
module sync_2ff #(
    parameter int                 DATA_W  = 4,
    parameter logic [DATA_W-1:0]  RST_VAL = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] meta_p0;
    logic [DATA_W-1:0] sync_p1;

    // stage 0: metastability capture; stage 1: resolved value
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with scan-based debounce.
//   clk, rst : system clock, synchronous active-high reset
//   kp       : row in; col, key, key_valid, key_held out
// Each column is driven low for SCAN_DIV cycles; rows are sampled on the
// last cycle of each dwell. A full scan is classified after column 3 and
// the debounce FSM advances only at that point.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic                clk,
    input  logic                rst,
    keypad_scanner_if.master    kp
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [2:0] ones4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Key-count accumulator only needs to distinguish 0, 1 and "2 or more".
    function automatic logic [1:0] sat2(input logic [2:0] x);
        return (x >= 3'd2) ? 2'd2 : x[1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] hit);
        if (hit[0])      return 2'd0;
        else if (hit[1]) return 2'd1;
        else if (hit[2]) return 2'd2;
        else             return 2'd3;
    endfunction

    logic [3:0]       row_s;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_idx_q;
    logic [3:0]       col_q;
    logic [1:0]       acc_cnt_q;
    logic [3:0]       acc_key_q;

    logic             dwell_end;
    logic             scan_done;
    logic [3:0]       hit;
    logic [2:0]       col_cnt;
    logic [1:0]       scan_cnt;
    logic [3:0]       scan_key;
    scan_res_t        scan_res;

    kp_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    sync_2ff #(.DATA_W(4), .RST_VAL(4'hF)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (kp.row),
        .q   (row_s)
    );

    assign dwell_end = (div_q == DIV_LAST);
    assign scan_done = dwell_end && (col_idx_q == 2'd3);

    // Column timing: dwell counter and rotating active-low column drive
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
        end else if (dwell_end) begin
            div_q     <= '0;
            col_idx_q <= col_idx_q + 2'd1;
            col_q     <= {col_q[2:0], col_q[3]};
        end else begin
            div_q     <= div_q + DIV_W'(1);
        end
    end

    // Scan accumulation: include the current column's sample in the result
    assign hit      = ~row_s;
    assign col_cnt  = ones4(hit);
    assign scan_cnt = sat2({1'b0, acc_cnt_q} + col_cnt);
    assign scan_key = (col_cnt == 3'd1) ? key_at(low_row(hit), col_idx_q) : acc_key_q;

    always_comb begin
        scan_res = SCAN_NONE;
        if (scan_cnt == 2'd1)      scan_res = SCAN_SINGLE;
        else if (scan_cnt != 2'd0) scan_res = SCAN_MULTI;
    end

    always_ff @(posedge clk) begin
        if (rst || scan_done) begin
            acc_cnt_q <= 2'd0;
            acc_key_q <= 4'h0;
        end else if (dwell_end) begin
            acc_cnt_q <= scan_cnt;
            acc_key_q <= scan_key;
        end
    end

    // Debounce FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign cnt_inc = sat_inc(cnt_q);

    // Debounce FSM: next state, advanced only on a completed scan
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (scan_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_res == SCAN_SINGLE) begin
                        cand_d = scan_key;
                        if (CNT_ONE >= CNT_MAX) begin
                            // single-scan debounce accepts immediately
                            state_d     = ST_PRESSED;
                            cnt_d       = '0;
                            key_d       = scan_key;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (scan_res == SCAN_SINGLE && scan_key == cand_q) begin
                        if (cnt_inc >= CNT_MAX) begin
                            state_d     = ST_PRESSED;
                            cnt_d       = '0;
                            key_d       = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (scan_res == SCAN_NONE) begin
                        if (CNT_ONE >= CNT_MAX) begin
                            state_d    = ST_IDLE;
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                        end else begin
                            state_d = ST_RELEASE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (scan_res == SCAN_NONE) begin
                        if (cnt_inc >= CNT_MAX) begin
                            state_d    = ST_IDLE;
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // bounce during release: back to held, no new pulse
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign kp.col       = col_q;
    assign kp.key       = key_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
endmodule
